// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the EX stage (DIV/DIVU), producing {HI, LO} = {rem, quo}.
// Build option: define DIV_ZERO_FAST_EN to finish a divide-by-zero straight from IDLE without iterating.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic               stall_div,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  // Handshake: start is a level request held by the stalled pipeline; ready is a one-cycle
  // pulse with result valid; annul wins over start in every state and suppresses ready.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               neg_q, neg_d;
  logic               sign_a_q, sign_a_d;
  logic               bzero_q, bzero_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               a_neg, b_neg, load, last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shl_rem, trial;
  logic [WIDTH-1:0]   step_rem, step_quo, fix_rem, fix_quo;

  assign a_neg = signed_div & a[WIDTH-1];
  assign b_neg = signed_div & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign load  = (state_q == IDLE) & start & ~annul;
  assign last  = (state_q == BUSY) & (cnt_q == LAST_STEP);

  // One restoring step; rem < divisor always, so WIDTH+1 bits hold the shifted remainder.
  always_comb begin
    shl_rem = {rem_q, quo_q[WIDTH-1]};
    trial   = shl_rem - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      step_rem = trial[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = shl_rem[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b0};
    end
    fix_quo = neg_q    ? -step_quo : step_quo;
    fix_rem = sign_a_q ? -step_rem : step_rem;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (annul) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
`ifdef DIV_ZERO_FAST_EN
            state_d = (b == '0) ? DONE : BUSY;
`else
            state_d = BUSY;
`endif
          end
        end
        BUSY:    if (cnt_q == LAST_STEP) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ready     = (state_q == DONE) & ~annul;
    stall_div = ~annul & ((start & (state_q == IDLE)) | (state_q == BUSY));
  end

  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    a_d      = a_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    bzero_d  = bzero_q;
    result_d = result_q;
    if (load) begin
      cnt_d    = '0;
      rem_d    = '0;
      quo_d    = a_mag;
      dvs_d    = b_mag;
      a_d      = a;
      neg_d    = a_neg ^ b_neg;
      sign_a_d = a_neg;
      bzero_d  = (b == '0);
`ifdef DIV_ZERO_FAST_EN
      if (b == '0) result_d = {a, {WIDTH{1'b1}}};
`endif
    end else if ((state_q == BUSY) && !annul) begin
      cnt_d = cnt_q + 6'd1;
      rem_d = step_rem;
      quo_d = step_quo;
      // Divide-by-zero result is forced rather than taken from the iterations.
      if (last) result_d = bzero_q ? {a_q, {WIDTH{1'b1}}} : {fix_rem, fix_quo};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      bzero_q  <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      a_q      <= a_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      bzero_q  <= bzero_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, random operands against an arithmetic model,
// annul, mid-operation reset and back-to-back divides.
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         signed_div = 1'b0;
  logic         annul = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         stall_div;
  logic         ready;
  logic [2*W-1:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_cyc = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_res = '0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul),
    .stall_div(stall_div), .ready(ready), .result(result)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: plain integer division, truncating toward zero.
  function automatic logic [2*W-1:0] ref_div(input logic sd, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W-1:0] sx, sy, q, r;
    if (y == 0) return {x, 32'hFFFF_FFFF};
    if (!sd) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sx = x; sy = y;
    q = sx / sy;
    r = sx % sy;
    return {r, q};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] y);
`ifdef DIV_ZERO_FAST_EN
    if (y == 0) return 1;
`endif
    return 33;
  endfunction

  // Driver: issue a divide with start held under stall, scramble operands afterwards,
  // and check latency, stall length and result. start stays high on return.
  task automatic run_div(input logic sd, input logic [W-1:0] x, input logic [W-1:0] y, input string name);
    int lat, stalls, exp_lat;
    bit got;
    logic [2*W-1:0] e;
    exp_q.push_back(ref_div(sd, x, y));
    exp_lat = ref_lat(y);
    @(posedge clk); #1;
    start = 1'b1; signed_div = sd; a = x; b = y;
    lat = -1; stalls = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (stall_div) stalls++;
      if (ready) begin
        got = 1; lat = i;
      end else if (i == 1) begin
        a = $urandom; b = $urandom; signed_div = 1'($urandom_range(0, 1));
      end
    end
    e = exp_q.pop_front();
    rdy_cyc = cyc;
    total++;
    if (!got || lat != exp_lat) begin
      bad++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    total++;
    if (result !== e) begin
      bad++; $display("FAIL %s result: got %h expected %h", name, result, e);
    end
    total++;
    if (stalls != exp_lat) begin
      bad++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_lat);
    end
    last_res = e;
  endtask

  // Drop start and check that ready was a single-cycle pulse.
  task automatic go_idle(input int n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL ready_one_cycle: got %b expected 0", ready);
    end
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (ready !== 1'b0 || stall_div !== 1'b0 || result !== '0) begin
      bad++; $display("FAIL reset_outputs: got ready=%b stall=%b result=%h expected 0 0 0", ready, stall_div, result);
    end
    start = 1'b1;
    #1;
    total++;
    if (stall_div !== 1'b1) begin
      bad++; $display("FAIL reset_idle_stall: got %b expected 1", stall_div);
    end
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_directed();
    run_div(1'b0, 32'd100, 32'd7, "divu_100_7");              go_idle(1);
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, "div_m100_7");        go_idle(1);
    run_div(1'b1, 32'd100, 32'hFFFF_FFF9, "div_100_m7");      go_idle(1);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");   go_idle(1);
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");  go_idle(1);
    run_div(1'b0, 32'h0000_1234, 32'd0, "divu_zero");         go_idle(1);
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, "div_zero");          go_idle(1);
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic sd;
    for (int n = 0; n < 16; n++) begin
      sd = 1'($urandom_range(0, 1));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = W'($urandom_range(1, 20));
        3: y = -W'($urandom_range(1, 20));
        default: ;
      endcase
      run_div(sd, x, y, "random");
      go_idle(0);
    end
  endtask

  task automatic test_annul();
    bit seen = 0;
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    total++;
    if (stall_div !== 1'b0 || ready !== 1'b0) begin
      bad++; $display("FAIL annul_cycle: got stall=%b ready=%b expected 0 0", stall_div, ready);
    end
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL annul_no_ready: got ready pulse expected none");
    end
    total++;
    if (result !== last_res) begin
      bad++; $display("FAIL annul_hold: got %h expected %h", result, last_res);
    end
    repeat (2) @(posedge clk);
    run_div(1'b0, 32'd9, 32'd3, "after_annul");
    go_idle(1);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b1; a = 32'hDEAD_BEEF; b = 32'd13;
    repeat (20) @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ready !== 1'b0 || stall_div !== 1'b0 || result !== '0) begin
      bad++; $display("FAIL reset_mid: got ready=%b stall=%b result=%h expected 0 0 0", ready, stall_div, result);
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready || stall_div) seen = 1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL reset_quiet: got ready/stall activity expected none");
    end
    last_res = '0;
  endtask

  task automatic test_back_to_back();
    int first;
    run_div(1'b0, 32'd1000, 32'd10, "b2b_first");
    first = rdy_cyc;
    run_div(1'b1, 32'hFFFF_FC18, 32'd3, "b2b_second");
    total++;
    if (rdy_cyc - first < 34) begin
      bad++; $display("FAIL b2b_spacing: got %0d expected >= 34", rdy_cyc - first);
    end
    go_idle(1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
